// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared widths and state/grant types for the RAM arbiter
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } grant_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - fetch/data requester handshakes plus the RAM port, grouped as one bus
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              ram_wren;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_q,
    output if_ack, if_rdata, dm_ack, dm_rdata, ram_wren, ram_address, ram_data, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_q,
    input  if_ack, if_rdata, dm_ack, dm_rdata, ram_wren, ram_address, ram_data, busy
  );

endinterface

// File: rtl/ram_arbiter_pick.sv
// rtl/ram_arbiter_pick.sv - combinational winner select; RAM_ARB_RR_EN selects round-robin ties
module arb_pick
  import ram_arb_pkg::*;
(
  input  logic   if_elig,
  input  logic   dm_elig,
`ifdef RAM_ARB_RR_EN
  input  logic   last_grant,
`endif
  output grant_t pick
);

  always_comb begin
    pick = NONE;
    if (if_elig && dm_elig) begin
`ifdef RAM_ARB_RR_EN
      // last_grant: 1 = data won last time, so fetch takes this tie
      pick = last_grant ? FETCH : DATA;
`else
      pick = DATA;
`endif
    end else if (dm_elig) begin
      pick = DATA;
    end else if (if_elig) begin
      pick = FETCH;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one 256x8 sync RAM between fetch and data ports; RAM_ARB_RR_EN enables round-robin
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  arb_state_t        state;
  grant_t            grant;
  grant_t            pick;
  logic              if_ack_q, dm_ack_q, ram_wren_q, busy_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q, ram_data_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic              if_elig, dm_elig;

  // A requester acked this cycle may still show req high; do not reissue it.
  assign if_elig = bus.if_req && !if_ack_q;
  assign dm_elig = bus.dm_req && !dm_ack_q;

`ifdef RAM_ARB_RR_EN
  logic last_grant;

  arb_pick u_pick (
    .if_elig    (if_elig),
    .dm_elig    (dm_elig),
    .last_grant (last_grant),
    .pick       (pick)
  );
`else
  arb_pick u_pick (
    .if_elig (if_elig),
    .dm_elig (dm_elig),
    .pick    (pick)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= NONE;
      if_ack_q      <= 1'b0;
      dm_ack_q      <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      busy_q        <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_grant    <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != NONE) begin
            grant  <= pick;
            state  <= ACCESS;
            busy_q <= 1'b1;
`ifdef RAM_ARB_RR_EN
            last_grant <= (pick == DATA);
`endif
            if (pick == DATA) begin
              ram_address_q <= bus.dm_addr;
              ram_data_q    <= bus.dm_wdata;
              ram_wren_q    <= bus.dm_we;
            end else begin
              ram_address_q <= bus.if_addr;
              ram_wren_q    <= 1'b0;
            end
          end else begin
            ram_wren_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        ACCESS: begin
          // ram_wren doubles as the latched write flag for this access
          ram_wren_q <= 1'b0;
          if (ram_wren_q) begin
            dm_ack_q <= 1'b1;
            grant    <= NONE;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          if (grant == FETCH) begin
            if_rdata_q <= bus.ram_q;
            if_ack_q   <= 1'b1;
          end else begin
            dm_rdata_q <= bus.ram_q;
            dm_ack_q   <= 1'b1;
          end
          grant  <= NONE;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_ack      = if_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.busy        = busy_q;

endmodule
